// File: rtl/clock_set_ctrl.sv
// Time-setting controller: edits a shadow hour/minute through
// RUN -> EDIT_HOUR -> EDIT_MIN -> RUN and strobes load on commit.
// Optional feature macro: BTN_AUTOREPEAT_EN (held UP/DOWN auto-repeats).
module clock_set_ctrl #(
    parameter int unsigned HOUR_MAX    = 23,
    parameter int unsigned MIN_MAX     = 59,
    parameter int unsigned TIMEOUT_CYC = 1900
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY = 95,
    parameter int unsigned REPEAT_RATE  = 19
`endif
) (
    input  logic       clk190,
    input  logic       rst_n,
    input  logic [2:0] btn_in,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    output logic [1:0] mode,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic       load
);

    localparam int unsigned HW = 5;
    localparam int unsigned MW = 6;
    localparam int unsigned IW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [HW-1:0] HMAX = HW'(HOUR_MAX);
    localparam logic [MW-1:0] MMAX = MW'(MIN_MAX);

    typedef enum logic [1:0] {
        S_RUN  = 2'b00,
        S_HOUR = 2'b01,
        S_MIN  = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    btn_q;
    logic [HW-1:0] hour_q, hour_d;
    logic [MW-1:0] min_q, min_d;
    logic          load_q, load_d;
    logic [IW-1:0] idle_q, idle_d;

    logic [2:0]    press;
    logic          up_step, dn_step, do_up, do_dn;
    logic          rep_up, rep_dn;
    logic [HW-1:0] hour_inc, hour_dec, hour_cap;
    logic [MW-1:0] min_inc, min_dec, min_cap;

    // Edge detect and field arithmetic with wrap / capture clamping
    always_comb begin
        press    = btn_in & ~btn_q;
        up_step  = press[1] & ~press[2];
        dn_step  = press[2] & ~press[1];
        hour_inc = (hour_q == HMAX) ? '0 : hour_q + HW'(1);
        hour_dec = (hour_q == '0) ? HMAX : hour_q - HW'(1);
        min_inc  = (min_q == MMAX) ? '0 : min_q + MW'(1);
        min_dec  = (min_q == '0) ? MMAX : min_q - MW'(1);
        hour_cap = (cur_hour > HMAX) ? HMAX : cur_hour;
        min_cap  = (cur_min > MMAX) ? MMAX : cur_min;
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_DELAY + 1);
    logic [RW-1:0] rep_q, rep_d;
    logic          held_up, held_dn;

    // Hold counter: first extra step after REPEAT_DELAY, then every REPEAT_RATE
    always_comb begin
        rep_d   = '0;
        rep_up  = 1'b0;
        rep_dn  = 1'b0;
        held_up = btn_in[1] & ~btn_in[2];
        held_dn = btn_in[2] & ~btn_in[1];
        if (state_q != S_RUN && !press[0] && (held_up || held_dn)) begin
            if (press[1] || press[2]) begin
                rep_d = '0;
            end else if (rep_q == RW'(REPEAT_DELAY - 1)) begin
                rep_d  = RW'(REPEAT_DELAY - REPEAT_RATE);
                rep_up = held_up;
                rep_dn = held_dn;
            end else begin
                rep_d = rep_q + RW'(1);
            end
        end
        if (state_d != state_q) begin
            rep_d = '0;
        end
    end

    // Repeat counter register
    always_ff @(posedge clk190 or negedge rst_n) begin
        if (!rst_n) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    // No auto-repeat: only press edges step the fields
    always_comb begin
        rep_up = 1'b0;
        rep_dn = 1'b0;
    end
`endif

    // Next state, shadow edits, idle timeout and commit strobe
    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        load_d  = 1'b0;
        idle_d  = idle_q;
        do_up   = up_step | rep_up;
        do_dn   = dn_step | rep_dn;
        case (state_q)
            S_RUN: begin
                idle_d = '0;
                if (press[0]) begin
                    state_d = S_HOUR;
                    hour_d  = hour_cap;
                    min_d   = min_cap;
                end
            end
            S_HOUR, S_MIN: begin
                if (press[0]) begin
                    state_d = (state_q == S_HOUR) ? S_MIN : S_RUN;
                    load_d  = (state_q == S_MIN);
                    idle_d  = '0;
                end else if ((|press) || do_up || do_dn) begin
                    idle_d = '0;
                    if (state_q == S_HOUR) begin
                        if (do_up)      hour_d = hour_inc;
                        else if (do_dn) hour_d = hour_dec;
                    end else begin
                        if (do_up)      min_d = min_inc;
                        else if (do_dn) min_d = min_dec;
                    end
                end else if (idle_q == IW'(TIMEOUT_CYC - 1)) begin
                    state_d = S_RUN;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end
            default: begin
                state_d = S_RUN;
                idle_d  = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk190 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            btn_q   <= '0;
            hour_q  <= '0;
            min_q   <= '0;
            load_q  <= 1'b0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            btn_q   <= btn_in;
            hour_q  <= hour_d;
            min_q   <= min_d;
            load_q  <= load_d;
            idle_q  <= idle_d;
        end
    end

    assign mode     = state_q;
    assign set_hour = hour_q;
    assign set_min  = min_q;
    assign load     = load_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with hand-computed expectations.
module tb_clock_set_ctrl;

    logic       clk190 = 1'b0;
    logic       rst_n;
    logic [2:0] btn_in;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [1:0] mode;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic       load;

    int errors   = 0;
    int checks   = 0;
    int load_cnt = 0;

    clock_set_ctrl dut (
        .clk190   (clk190),
        .rst_n    (rst_n),
        .btn_in   (btn_in),
        .cur_hour (cur_hour),
        .cur_min  (cur_min),
        .mode     (mode),
        .set_hour (set_hour),
        .set_min  (set_min),
        .load     (load)
    );

    always #5 clk190 = ~clk190;

    // Count every cycle in which load is high
    always @(negedge clk190) begin
        if (load === 1'b1) load_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk190);
        #1;
    endtask

    task automatic hit(input logic [2:0] b);
        btn_in = b;
        tick(1);
    endtask

    task automatic rel();
        btn_in = 3'b000;
        tick(1);
    endtask

    initial begin
        int exp_min;
        rst_n    = 1'b0;
        btn_in   = 3'b000;
        cur_hour = 5'd12;
        cur_min  = 6'd34;
        tick(3);
        chk("rst_mode_in", int'(mode), 0);
        chk("rst_load_in", int'(load), 0);
        rst_n = 1'b1;
        tick(1);
        chk("rst_mode", int'(mode), 0);
        chk("rst_hour", int'(set_hour), 0);
        chk("rst_min", int'(set_min), 0);
        chk("rst_load", int'(load), 0);

        // 12:34 -> edit -> 12:37 -> commit
        hit(3'b001);
        chk("t2_mode_h", int'(mode), 1);
        chk("t2_cap_h", int'(set_hour), 12);
        chk("t2_cap_m", int'(set_min), 34);
        rel();
        hit(3'b001);
        chk("t2_mode_m", int'(mode), 2);
        rel();
        for (int i = 0; i < 3; i++) begin
            hit(3'b010);
            rel();
        end
        chk("t2_min37", int'(set_min), 37);
        hit(3'b001);
        chk("t2_load", int'(load), 1);
        chk("t2_mode_run", int'(mode), 0);
        chk("t2_hour", int'(set_hour), 12);
        chk("t2_min", int'(set_min), 37);
        rel();
        chk("t2_load_drop", int'(load), 0);
        chk("t2_load_cnt", load_cnt, 1);
        hit(3'b010);
        rel();
        chk("run_up_ign", int'(set_min), 37);
        chk("run_mode", int'(mode), 0);

        // Wrap boundaries
        cur_hour = 5'd23;
        cur_min  = 6'd59;
        hit(3'b001);
        chk("t3_cap23", int'(set_hour), 23);
        rel();
        hit(3'b010);
        chk("t3_h_wrap_up", int'(set_hour), 0);
        rel();
        hit(3'b100);
        chk("t3_h_wrap_dn", int'(set_hour), 23);
        rel();
        hit(3'b001);
        chk("t3_mode_m", int'(mode), 2);
        rel();
        hit(3'b010);
        chk("t3_m_wrap_up", int'(set_min), 0);
        rel();
        hit(3'b100);
        chk("t3_m_wrap_dn", int'(set_min), 59);
        rel();
        hit(3'b001);
        chk("t3_load", int'(load), 1);
        rel();
        chk("t3_load_cnt", load_cnt, 2);

        // Simultaneous presses: MODE wins, UP+DOWN cancel
        hit(3'b001);
        chk("t4_mode_h", int'(mode), 1);
        rel();
        hit(3'b111);
        chk("t4_mode_pri", int'(mode), 2);
        chk("t4_hour_keep", int'(set_hour), 23);
        rel();
        hit(3'b110);
        chk("t4_ud_mode", int'(mode), 2);
        chk("t4_ud_min", int'(set_min), 59);
        chk("t4_ud_hour", int'(set_hour), 23);
        rel();

        // Idle timeout in EDIT_MIN: 1900 edges after the last press
        tick(1898);
        chk("t5_before_to", int'(mode), 2);
        tick(1);
        chk("t5_timeout", int'(mode), 0);
        chk("t5_no_load", load_cnt, 2);

        // Out-of-range live time is clamped on capture
        cur_hour = 5'd31;
        cur_min  = 6'd63;
        hit(3'b001);
        chk("clamp_h", int'(set_hour), 23);
        chk("clamp_m", int'(set_min), 59);
        rel();
        hit(3'b001);
        rel();
        hit(3'b001);
        rel();
        chk("clamp_load_cnt", load_cnt, 3);

        // Held UP for 95+19*3 cycles
        cur_hour = 5'd5;
        cur_min  = 6'd10;
        hit(3'b001);
        rel();
        hit(3'b001);
        chk("t6_start", int'(set_min), 10);
        rel();
        btn_in = 3'b010;
        tick(152);
        btn_in = 3'b000;
        tick(1);
`ifdef BTN_AUTOREPEAT_EN
        exp_min = 14;
`else
        exp_min = 11;
`endif
        chk("t6_hold", int'(set_min), exp_min);
        chk("t6_hour", int'(set_hour), 5);
        hit(3'b001);
        chk("t6_load", int'(load), 1);
        rel();
        chk("t6_load_cnt", load_cnt, 4);

        // Button held through reset reads as a press after release
        rst_n    = 1'b0;
        btn_in   = 3'b001;
        cur_hour = 5'd1;
        cur_min  = 6'd2;
        tick(2);
        chk("rh_in_rst", int'(mode), 0);
        rst_n = 1'b1;
        tick(1);
        chk("rh_mode", int'(mode), 1);
        chk("rh_hour", int'(set_hour), 1);
        chk("rh_min", int'(set_min), 2);
        rel();

        // Press on the timeout cycle is processed instead of timing out
        tick(1898);
        chk("tp_before", int'(mode), 1);
        hit(3'b010);
        chk("tp_mode", int'(mode), 1);
        chk("tp_hour", int'(set_hour), 2);
        rel();
        tick(1898);
        chk("tp_restart", int'(mode), 1);
        tick(1);
        chk("tp_timeout", int'(mode), 0);
        chk("tp_no_load", load_cnt, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
